// File: rtl/tm_pkg.sv
// Shared definitions for the Turing machine program loader and core.
// Holds the loader state encoding and the default word width / program
// depth constants used by both the loader and the TuringMachine core.
package tm_pkg;

  // Default data word width, matching the core's input_data bus
  localparam int TM_DW = 4;
  // Default program buffer depth in words
  localparam int TM_W  = 64;

  // Loader state encoding; S_STEP is only reachable with auto-stepping
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DONE_SETUP,
    S_DONE_PULSE,
    S_STEP
  } loader_state_e;

endpackage

// File: rtl/tm_phase_timer.sv
// Loadable down-counter with a zero flag. Loading N gives N+1 cycles
// until zero is seen, so the loader loads (phase length - 1) to time
// the Next-high and Next-low phases.
module tm_phase_timer #(
  parameter int TW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] count_q;

  // Count down to zero and hold there until the next load
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - TW'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/tm_program_loader.sv
// Transmitter side of the Turing machine program-entry handshake.
// Replays a buffered word stream onto input_data/Next, then presents the
// tape start index with a single-cycle Done strobe. All handshake outputs
// are registered so the core sees glitch-free strobes.
// Optional feature macro: TM_LOADER_AUTOSTEP_EN adds compute_done and a
// STEP state that keeps pulsing Next after Done until the core finishes.
module tm_program_loader
  import tm_pkg::*;
#(
  parameter int DW   = TM_DW,
  parameter int W    = TM_W,
  parameter int AW   = $clog2(W),
  parameter int HOLD = 2,
  parameter int GAP  = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_wdata,
  input  logic [AW:0]   prog_len,
  input  logic [DW-1:0] tape_start,
  input  logic          start,
`ifdef TM_LOADER_AUTOSTEP_EN
  input  logic          compute_done,
`endif
  output logic [DW-1:0] input_data,
  output logic          Next,
  output logic          Done,
  output logic          busy,
  output logic [AW:0]   sent_count,
  output logic          load_done
);

  localparam int PH_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int TW     = $clog2(PH_MAX) + 1;
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] W_LEN = (AW+1)'(W);

  loader_state_e state_q, state_n;

  logic [DW-1:0] buf_q [W];
  logic [AW:0]   len_q, len_n, idx_q, idx_n, sent_n, len_clamp, rd_idx;
  logic [DW-1:0] tape_q, tape_n, data_n, rd_word;
  logic          next_n, done_n, busy_n, wr_en;
  logic          tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;
`ifdef TM_LOADER_AUTOSTEP_EN
  logic          step_hi_q, step_hi_n;
`endif

  // Buffer writes are only accepted while the loader is idle
  assign wr_en     = prog_we && (state_q == S_IDLE);
  assign len_clamp = (prog_len > W_LEN) ? W_LEN : prog_len;

  tm_phase_timer #(.TW(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Program buffer storage; contents survive reset
  always_ff @(posedge clock) begin
    if (wr_en) begin
      buf_q[prog_addr] <= prog_wdata;
    end
  end

  // Fetch the word for the next SETUP, forwarding a same-cycle write
  always_comb begin
    rd_idx  = (state_q == S_GAP) ? (idx_q + ONE) : '0;
    rd_word = '0;
    if (rd_idx < W_LEN) begin
      rd_word = buf_q[rd_idx[AW-1:0]];
    end
    if (wr_en && (prog_addr == rd_idx[AW-1:0])) begin
      rd_word = prog_wdata;
    end
  end

  // Next-state logic and next values of the registered outputs
  always_comb begin
    state_n  = state_q;
    len_n    = len_q;
    tape_n   = tape_q;
    idx_n    = idx_q;
    sent_n   = sent_count;
    data_n   = input_data;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef TM_LOADER_AUTOSTEP_EN
    step_hi_n = step_hi_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_n  = len_clamp;
          tape_n = tape_start;
          idx_n  = '0;
          sent_n = '0;
          if (len_clamp != '0) begin
            state_n = S_SETUP;
            data_n  = rd_word;
          end else begin
            state_n = S_DONE_SETUP;
            data_n  = tape_start;
          end
        end
      end
      S_SETUP: begin
        state_n  = S_PULSE;
        tmr_load = 1'b1;
        tmr_val  = TW'(HOLD - 1);
      end
      S_PULSE: begin
        if (tmr_zero) begin
          state_n  = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP - 1);
        end
      end
      S_GAP: begin
        if (tmr_zero) begin
          sent_n = sent_count + ONE;
          idx_n  = idx_q + ONE;
          if (sent_n < len_q) begin
            state_n = S_SETUP;
            data_n  = rd_word;
          end else begin
            state_n = S_DONE_SETUP;
            data_n  = tape_q;
          end
        end
      end
      S_DONE_SETUP: begin
        state_n = S_DONE_PULSE;
      end
      S_DONE_PULSE: begin
`ifdef TM_LOADER_AUTOSTEP_EN
        state_n   = S_STEP;
        step_hi_n = 1'b1;
        tmr_load  = 1'b1;
        tmr_val   = TW'(HOLD - 1);
`else
        state_n = S_IDLE;
`endif
      end
      S_STEP: begin
`ifdef TM_LOADER_AUTOSTEP_EN
        if (compute_done) begin
          state_n   = S_IDLE;
          step_hi_n = 1'b0;
        end else if (tmr_zero) begin
          step_hi_n = !step_hi_q;
          tmr_load  = 1'b1;
          tmr_val   = step_hi_q ? TW'(GAP - 1) : TW'(HOLD - 1);
        end
`else
        state_n = S_IDLE;
`endif
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    next_n = (state_n == S_PULSE);
`ifdef TM_LOADER_AUTOSTEP_EN
    next_n = next_n || ((state_n == S_STEP) && step_hi_n);
`endif
    done_n = (state_n == S_DONE_PULSE);
    busy_n = (state_n != S_IDLE);
  end

  // State, run bookkeeping and registered handshake outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      tape_q     <= '0;
      idx_q      <= '0;
      sent_count <= '0;
      input_data <= '0;
      Next       <= 1'b0;
      Done       <= 1'b0;
      load_done  <= 1'b0;
      busy       <= 1'b0;
`ifdef TM_LOADER_AUTOSTEP_EN
      step_hi_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      len_q      <= len_n;
      tape_q     <= tape_n;
      idx_q      <= idx_n;
      sent_count <= sent_n;
      input_data <= data_n;
      Next       <= next_n;
      Done       <= done_n;
      load_done  <= done_n;
      busy       <= busy_n;
`ifdef TM_LOADER_AUTOSTEP_EN
      step_hi_q  <= step_hi_n;
`endif
    end
  end

endmodule

// File: tb/tb_tm_program_loader.sv
// Scoreboard bench for tm_program_loader: each start pushes the expected
// word strobes and the Done strobe; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_tm_program_loader;
  import tm_pkg::*;

  localparam int DW     = 4;
  localparam int W      = 64;
  localparam int AW     = $clog2(W);
  localparam int HOLD   = 2;
  localparam int GAP    = 2;
  localparam int WORD_T = 1 + HOLD + GAP;
`ifdef TM_LOADER_AUTOSTEP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_wdata = '0;
  logic [AW:0]   prog_len = '0;
  logic [DW-1:0] tape_start = '0;
  logic          start = 1'b0;
  logic [DW-1:0] input_data;
  logic          Next, Done, busy, load_done;
  logic [AW:0]   sent_count;
`ifdef TM_LOADER_AUTOSTEP_EN
  logic          compute_done = 1'b0;
`endif

  tm_program_loader #(.DW(DW), .W(W), .HOLD(HOLD), .GAP(GAP)) dut (
    .clock        (clock),
    .reset        (reset),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_wdata   (prog_wdata),
    .prog_len     (prog_len),
    .tape_start   (tape_start),
    .start        (start),
`ifdef TM_LOADER_AUTOSTEP_EN
    .compute_done (compute_done),
`endif
    .input_data   (input_data),
    .Next         (Next),
    .Done         (Done),
    .busy         (busy),
    .sent_count   (sent_count),
    .load_done    (load_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            is_done;
    logic [DW-1:0] data;
    int            at;
    int            sent;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_buf [W];
  int            cyc = 0;
  int            base = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  bit            in_step = 1'b0;
  exp_t          e;
  logic [DW-1:0] cur = '0;
  bit            pn = 1'b0;
  bit            pd = 1'b0;
  int            hl = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc - base);
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: pops one scoreboard entry per Next or Done rising edge
  initial forever begin
    @(negedge clock);
    if (reset) begin
      pn = 1'b0; pd = 1'b0; hl = 0;
    end else begin
      if (Next && !pn && !in_step) begin
        if (sb.size() == 0) check("unexpected_next", 1, 0);
        else begin
          e = sb.pop_front();
          cur = e.data;
          check("next_kind", e.is_done, 0);
          check("next_time", cyc - base, e.at);
          check("next_excl_done", Done, 0);
        end
      end
      if (Next && !in_step) check("next_data", input_data, cur);
      if (Next) hl++;
      else begin
        if (pn && !in_step) check("hold_len", hl, HOLD);
        hl = 0;
      end
      if (Done && !pd) begin
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("done_kind", e.is_done, 1);
          check("done_time", cyc - base, e.at);
          check("done_data", input_data, e.data);
          check("done_sent", sent_count, e.sent);
          check("done_load_done", load_done, 1);
          check("done_excl_next", Next, 0);
        end
        in_step = AUTO;
      end
      if (!Done && pd) begin
        check("after_done_busy", busy, AUTO);
        check("after_done_pulse", load_done, 0);
      end
      pn = Next;
      pd = Done;
      if (!busy) in_step = 1'b0;
    end
  end

  task automatic write_word(input int a, input logic [DW-1:0] d);
    @(negedge clock);
    prog_we = 1'b1; prog_addr = AW'(a); prog_wdata = d;
    model_buf[a] = d;
    @(negedge clock);
    prog_we = 1'b0;
  endtask

  task automatic start_run(input int len, input logic [DW-1:0] tape, input int wa, input logic [DW-1:0] wd);
    int n;
    n = (len > W) ? W : len;
    @(negedge clock);
    if (wa >= 0) begin
      prog_we = 1'b1; prog_addr = AW'(wa); prog_wdata = wd;
      model_buf[wa] = wd;
    end
    start = 1'b1; prog_len = (AW+1)'(len); tape_start = tape; base = cyc;
    for (int i = 0; i < n; i++)
      sb.push_back('{is_done: 1'b0, data: model_buf[i], at: 2 + i * WORD_T, sent: 0});
    sb.push_back('{is_done: 1'b1, data: tape, at: n * WORD_T + 2, sent: n});
    @(negedge clock);
    start = 1'b0; prog_we = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    int steps;
    int nhi;
    t = 0; steps = 0; nhi = 0;
    @(negedge clock);
    while (busy && t < 2000) begin
`ifdef TM_LOADER_AUTOSTEP_EN
      if (in_step) begin
        steps++;
        if (Next) nhi++;
        if (steps == 12) begin
          compute_done = 1'b1;
          @(negedge clock);
          compute_done = 1'b0;
          check("step_pulses", (nhi > 0), 1);
          check("step_stop_next", Next, 0);
          check("step_stop_busy", busy, 0);
        end
      end
`endif
      if (busy) begin
        @(negedge clock);
        t++;
      end
    end
    if (t >= 2000) check("idle_timeout", 1, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_next", Next, 0);
    check("rst_done", Done, 0);
    check("rst_data", input_data, 0);
    check("rst_busy", busy, 0);
    check("rst_sent", sent_count, 0);
    check("rst_load_done", load_done, 0);
    reset = 1'b0;

    // Basic three-word program
    write_word(0, 4'd5);
    write_word(1, 4'd9);
    write_word(2, 4'd2);
    start_run(3, 4'd3, -1, '0);
    wait_idle();
    check("run1_sent", sent_count, 3);

    // Empty program goes straight to Done
    start_run(0, 4'd7, -1, '0);
    wait_idle();
    check("len0_sent", sent_count, 0);

    // start and prog_we while busy are both dropped
    start_run(3, 4'd4, -1, '0);
    repeat (5) @(negedge clock);
    start = 1'b1; prog_len = (AW+1)'(1); tape_start = 4'd15;
    prog_we = 1'b1; prog_addr = '0; prog_wdata = 4'd15;
    @(negedge clock);
    start = 1'b0; prog_we = 1'b0;
    wait_idle();
    start_run(3, 4'd4, -1, '0);
    wait_idle();

    // Write landing in the same cycle as start is transmitted
    start_run(3, 4'd1, 0, 4'd11);
    wait_idle();

    // Reset during the second word's strobe
    start_run(3, 4'd6, -1, '0);
    t = 0;
    while ((cyc - base) < 7 && t < 50) begin
      @(negedge clock);
      t++;
    end
    check("pre_rst_next", Next, 1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_next", Next, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sent", sent_count, 0);
    check("midrst_data", input_data, 0);
    reset = 1'b0;
    sb.delete();
    start_run(3, 4'd6, -1, '0);
    wait_idle();
    check("rerun_sent", sent_count, 3);

    // Over-long length is clamped to the buffer depth
    for (int i = 0; i < W; i++) write_word(i, DW'((i * 7 + 3) % 16));
    start_run(100, 4'd9, -1, '0);
    wait_idle();
    check("clamp_sent", sent_count, W);

    repeat (3) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tm_program_loader.md
Name: tm_program_loader

Overview:
- Transmitter side of the Turing machine program-entry handshake.
- Replays a buffered program (word stream) onto the machine's input_data/Next/Done pins, as an operator would by hand.
- Then asserts Done with the tape start index on input_data.
- Sits between a host/ROM write port and the TuringMachine core; lets benches and top-levels load programs without manual button timing.

Parameters:
- DW, 4, word width; matches the core's input_data width.
- W, 64, program buffer depth in words.
- AW, $clog2(W), buffer address width.
- HOLD, 2, cycles Next stays high per word (>=1).
- GAP, 2, cycles Next stays low between words and before Done (>=1).

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- prog_we  input  1  write one buffer word; honoured only when busy=0.
- prog_addr  input  AW  buffer write address.
- prog_wdata  input  DW  buffer write data.
- prog_len  input  AW+1  number of words to send (0..W); sampled on start.
- tape_start  input  DW  tape start index; sampled on start, driven during Done.
- start  input  1  begin transmission; honoured only when busy=0.
- input_data  output  DW  word presented to the core.
- Next  output  1  word strobe to the core.
- Done  output  1  end-of-program strobe to the core.
- busy  output  1  high from the cycle after start until return to IDLE.
- sent_count  output  AW+1  words fully transmitted in the current run.
- load_done  output  1  one-cycle pulse in the cycle Done is asserted.

Behaviour:
- Reset: Next=0, Done=0, input_data=0, busy=0, sent_count=0, load_done=0, state=IDLE. Buffer contents are not cleared.
- Reset mid-run: all outputs return to reset values at the reset edge. The loader does not reset the core.
- States:
  - IDLE: on start, latch prog_len and tape_start, clear sent_count and index, then go to SETUP if len>0, else to DONE_SETUP.
  - SETUP: 1 cycle. input_data=buf[index], Next=0 (data is stable before the strobe edge). Then PULSE.
  - PULSE: Next=1 for exactly HOLD cycles, input_data held. Then GAP.
  - GAP: Next=0 for exactly GAP cycles, input_data held. On exit, sent_count++ and index++. Go to SETUP if sent_count<len, else DONE_SETUP.
  - DONE_SETUP: 1 cycle. input_data=tape_start, Next=0, Done=0.
  - DONE_PULSE: 1 cycle. Done=1, load_done=1, input_data=tape_start. Then IDLE (or STEP with the optional feature).
- Next and Done are never high in the same cycle. Both are registered outputs, glitch-free.
- Per-word latency: 1+HOLD+GAP cycles.
- Total run: len*(1+HOLD+GAP)+2 cycles from the start edge to the Done cycle inclusive.
- Buffer: W x DW register array, one write port, read by index. prog_we while busy=1 is dropped.
- prog_len>W is clamped to W.
- start while busy is ignored. start and prog_we in the same IDLE cycle: the write lands, and transmission reads the buffer from the next cycle (write visible).
- Arithmetic: sent_count and index are unsigned AW+1 bits. No wrap is possible because of the clamp.

Optional Feature:
- Macro: TM_LOADER_AUTOSTEP_EN.
- When defined:
  - Adds input port compute_done (1 bit, from the core's Compute_done).
  - After DONE_PULSE the loader enters STEP instead of IDLE and remains busy.
  - STEP repeats Next=1 for HOLD cycles, then Next=0 for GAP cycles, single-stepping the core until compute_done=1 is sampled.
  - On that sample, Next is forced 0 and the loader returns to IDLE.
  - compute_done high during the Next-high phase aborts the pulse on the next edge.
- When undefined: no compute_done port; the loader goes IDLE directly after DONE_PULSE and stepping is external.

Decomposition:
- Package tm_pkg:
  - loader state enum (IDLE, SETUP, PULSE, GAP, DONE_SETUP, DONE_PULSE, STEP).
  - default DW/W constants shared with TuringMachine.
- One sub-module, tm_phase_timer: a loadable down-counter with zero flag that generates the HOLD/GAP phase lengths. It is reused by STEP.

Test Plan:
- Program 3 words {5,9,2}, tape_start=3, HOLD=2, GAP=2, start -> Next high exactly cycles 2-3, 7-8, 12-13; input_data 5/9/2 stable from each SETUP through GAP; Done=1 in cycle 17 with input_data=3; sent_count=3.
- prog_len=0, start -> DONE_SETUP, then Done=1 two cycles after start; Next never asserted.
- start and prog_we pulsed mid-run -> both ignored; buffer unchanged; transmitted words match the original program.
- Reset asserted during PULSE of word 2 -> Next=0, busy=0, sent_count=0 at the next edge; a fresh start then replays from word 0.
- Loader connected to TuringMachine with a 2-state program -> the core's memory matches the buffer word-for-word; the core reaches READ_TAPE after Done.
- TM_LOADER_AUTOSTEP_EN defined -> Next pulses continue after Done until compute_done=1, then Next=0 and busy=0 within 1 cycle.
